// File: rtl/framebuffer_writer.sv
`default_nettype none
// ============================================================================
//  Module   : framebuffer_writer
//  Purpose  : Writes the renderer pixel stream into a double-buffered RGB565
//             framebuffer and swaps banks on display vsync after a full frame.
//  Revision : 1.0  initial release
// ============================================================================
module framebuffer_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 180,
  parameter int ADDR_W = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [23:0]       pixel_axis_tdata,
  input  logic              pixel_axis_tvalid,
  output logic              pixel_axis_tready,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              vsync_in,
  output logic [ADDR_W:0]   fb_addr,
  output logic [15:0]       fb_wdata,
  output logic              fb_we,
  output logic              display_bank,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count
);

  localparam logic [31:0] c_width  = 32'(WIDTH);
  localparam logic [31:0] c_height = 32'(HEIGHT);
  localparam logic [31:0] c_last_x = 32'(WIDTH - 1);
  localparam logic [31:0] c_last_y = 32'(HEIGHT - 1);

  typedef enum logic [0:0] {
    ST_WRITE     = 1'b0,
    ST_WAIT_SWAP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_wbank;
  logic              r_fb_we;
  logic [ADDR_W:0]   r_fb_addr;
  logic [15:0]       r_fb_wdata;
  logic              r_frame_done;
  logic [15:0]       r_frame_count;
  logic [15:0]       r_drop_count;

  logic              w_xfer;
  logic              w_in_bounds;
  logic              w_last_pixel;
  logic              w_swap;
  logic              w_write;
  logic              w_drop;
  logic [31:0]       w_pix_idx;
  logic [15:0]       w_rgb565;
  logic              w_unused;

  // The renderer may only push while a frame is open for writing.
  assign pixel_axis_tready = (r_state == ST_WRITE);
  assign w_xfer            = pixel_axis_tvalid && (r_state == ST_WRITE);

  assign w_in_bounds  = (32'(hcount_in) < c_width) && (32'(vcount_in) < c_height);
  assign w_last_pixel = (32'(hcount_in) == c_last_x) && (32'(vcount_in) == c_last_y);
  assign w_pix_idx    = 32'(vcount_in) * c_width + 32'(hcount_in);
  assign w_rgb565     = {pixel_axis_tdata[23:19], pixel_axis_tdata[15:10], pixel_axis_tdata[7:3]};

  assign w_write = w_xfer && w_in_bounds;
  assign w_drop  = w_xfer && !w_in_bounds;

  assign w_unused = ^{pixel_axis_tdata[18:16], pixel_axis_tdata[9:8],
                      pixel_axis_tdata[2:0], w_pix_idx[31:ADDR_W]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_WRITE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A vsync seen while still writing is ignored, so a frame can never swap early.
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      ST_WRITE: begin
        if (pixel_axis_tvalid && w_last_pixel) begin
          w_state_nxt = ST_WAIT_SWAP;
        end
      end
      ST_WAIT_SWAP: begin
        if (vsync_in) begin
          w_state_nxt = ST_WRITE;
          w_swap      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_WRITE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wbank       <= 1'b0;
      r_fb_we       <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_wdata    <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      r_fb_we      <= w_write;
      r_frame_done <= w_swap;
      if (w_write) begin
        r_fb_addr  <= {r_wbank, w_pix_idx[ADDR_W-1:0]};
        r_fb_wdata <= w_rgb565;
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_swap) begin
        r_wbank       <= ~r_wbank;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign fb_we        = r_fb_we;
  assign fb_addr      = r_fb_addr;
  assign fb_wdata     = r_fb_wdata;
  assign display_bank = ~r_wbank;
  assign frame_done   = r_frame_done;
  assign frame_count  = r_frame_count;
  assign drop_count   = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_framebuffer_writer
//  Purpose  : Directed self-checking bench for framebuffer_writer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_framebuffer_writer;

  logic        aclk;
  logic        aresetn;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        vsync;
  logic [16:0] fb_addr;
  logic [15:0] fb_wdata;
  logic        fb_we;
  logic        display_bank;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  framebuffer_writer #(.WIDTH(320), .HEIGHT(180), .ADDR_W(16)) u_dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .pixel_axis_tdata  (tdata),
    .pixel_axis_tvalid (tvalid),
    .pixel_axis_tready (tready),
    .hcount_in         (hcount),
    .vcount_in         (vcount),
    .vsync_in          (vsync),
    .fb_addr           (fb_addr),
    .fb_wdata          (fb_wdata),
    .fb_we             (fb_we),
    .display_bank      (display_bank),
    .frame_done        (frame_done),
    .frame_count       (frame_count),
    .drop_count        (drop_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rgb565(input logic [23:0] d);
    return {d[23:19], d[15:10], d[7:3]};
  endfunction

  // Called at a falling edge; returns at the next falling edge with the write visible.
  task automatic send_pixel(input logic [10:0] h, input logic [9:0] v, input logic [23:0] d);
    check("tready_pre", {31'd0, tready}, 32'd1);
    tvalid = 1'b1;
    hcount = h;
    vcount = v;
    tdata  = d;
    @(negedge aclk);
    tvalid = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_we"},     {31'd0, fb_we},        32'd0);
    check({pfx, "_addr"},   {15'd0, fb_addr},      32'd0);
    check({pfx, "_wdata"},  {16'd0, fb_wdata},     32'd0);
    check({pfx, "_dbank"},  {31'd0, display_bank}, 32'd1);
    check({pfx, "_fdone"},  {31'd0, frame_done},   32'd0);
    check({pfx, "_fcount"}, {16'd0, frame_count},  32'd0);
    check({pfx, "_drops"},  {16'd0, drop_count},   32'd0);
    check({pfx, "_tready"}, {31'd0, tready},       32'd1);
  endtask

  initial begin
    int          errs;
    int          nwr;
    logic [23:0] d;
    logic [10:0] h;
    logic [9:0]  v;
    logic        vld;

    aresetn = 1'b0;
    tvalid  = 1'b0;
    tdata   = '0;
    hcount  = '0;
    vcount  = '0;
    vsync   = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_values("rst");
    aresetn = 1'b1;
    @(negedge aclk);

    // Single pixel colour/address conversion
    send_pixel(11'd5, 10'd2, 24'hFF8040);
    check("t2_we",    {31'd0, fb_we},    32'd1);
    check("t2_addr",  {15'd0, fb_addr},  32'd645);
    check("t2_wdata", {16'd0, fb_wdata}, 32'h0000FC08);
    @(negedge aclk);
    check("t2_we_idle", {31'd0, fb_we}, 32'd0);

    // Out-of-bounds pixels are accepted and counted, never written
    send_pixel(11'd320, 10'd0, 24'h123456);
    check("t5_we_x",    {31'd0, fb_we},      32'd0);
    check("t5_drops_1", {16'd0, drop_count}, 32'd1);
    send_pixel(11'd0, 10'd180, 24'h654321);
    check("t5_we_y",    {31'd0, fb_we},      32'd0);
    check("t5_drops_2", {16'd0, drop_count}, 32'd2);

    // vsync during WRITE must not swap
    vsync = 1'b1;
    @(negedge aclk);
    vsync = 1'b0;
    check("t4_mid_fdone",  {31'd0, frame_done},   32'd0);
    check("t4_mid_fcount", {16'd0, frame_count},  32'd0);
    check("t4_mid_dbank",  {31'd0, display_bank}, 32'd1);

    // Full raster frame; vsync coincides with the last-pixel transfer
    errs = 0;
    for (int k = 0; k < 320 * 180; k++) begin
      d      = {k[7:0], k[10:3], k[15:8]};
      tvalid = 1'b1;
      hcount = 11'(k % 320);
      vcount = 10'(k / 320);
      tdata  = d;
      vsync  = (k == 320 * 180 - 1);
      @(negedge aclk);
      if (fb_we !== 1'b1) errs++;
      if (fb_addr !== 17'(k)) errs++;
      if (fb_wdata !== rgb565(d)) errs++;
      if (tready !== (k != 320 * 180 - 1)) errs++;
      if (k == 0) check("t1_first_addr", {15'd0, fb_addr}, 32'd0);
    end
    vsync = 1'b0;
    check("t1_raster_errs", errs, 32'd0);
    check("t1_last_addr",   {15'd0, fb_addr}, 32'd57599);
    check("t1_tready_low",  {31'd0, tready},  32'd0);

    // Stall: renderer keeps offering a pixel, nothing is written
    hcount = 11'd0;
    vcount = 10'd0;
    nwr    = 0;
    repeat (4) begin
      @(negedge aclk);
      if (fb_we) nwr++;
    end
    check("t4_stall_writes", nwr,                     32'd0);
    check("t4_stall_fcount", {16'd0, frame_count},    32'd0);
    check("t4_stall_dbank",  {31'd0, display_bank},   32'd1);
    check("t4_stall_tready", {31'd0, tready},         32'd0);

    // Bank swap on vsync
    tvalid = 1'b0;
    vsync  = 1'b1;
    @(negedge aclk);
    vsync = 1'b0;
    check("t3_fdone",  {31'd0, frame_done},   32'd1);
    check("t3_dbank",  {31'd0, display_bank}, 32'd0);
    check("t3_fcount", {16'd0, frame_count},  32'd1);
    check("t3_tready", {31'd0, tready},       32'd1);
    @(negedge aclk);
    check("t3_fdone_off", {31'd0, frame_done}, 32'd0);
    send_pixel(11'd5, 10'd2, 24'hFF8040);
    check("t3_bank1_we",   {31'd0, fb_we},   32'd1);
    check("t3_bank1_addr", {15'd0, fb_addr}, 32'h00010285);

    // Random tvalid gaps in the bank-1 frame
    for (int i = 0; i < 40; i++) begin
      vld    = 1'($urandom_range(0, 1));
      h      = 11'($urandom_range(0, 318));
      v      = 10'($urandom_range(0, 178));
      d      = 24'($urandom);
      tvalid = vld;
      hcount = h;
      vcount = v;
      tdata  = d;
      @(negedge aclk);
      check("t6_gap_we", {31'd0, fb_we}, {31'd0, vld});
      if (vld) begin
        check("t6_gap_addr", {15'd0, fb_addr}, 32'h10000 + 32'(v) * 32'd320 + 32'(h));
      end
    end

    // Asynchronous reset mid-frame, checked between clock edges
    tvalid = 1'b1;
    hcount = 11'd10;
    vcount = 10'd10;
    tdata  = 24'hABCDEF;
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
    check("t6_we_before_rst", {31'd0, fb_we}, 32'd1);
    aresetn = 1'b0;
    #1;
    check_reset_values("t6_async");
    @(negedge aclk);
    @(negedge aclk);
    check("t6_rst_held_we", {31'd0, fb_we}, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // After reset the writer is back on bank 0 and a lone last pixel ends a frame
    send_pixel(11'd5, 10'd2, 24'h0000FF);
    check("t6_post_addr",  {15'd0, fb_addr},  32'd645);
    check("t6_post_wdata", {16'd0, fb_wdata}, 32'h0000001F);
    send_pixel(11'd319, 10'd179, 24'hFFFFFF);
    check("t6_last_addr",   {15'd0, fb_addr}, 32'd57599);
    check("t6_last_tready", {31'd0, tready},  32'd0);
    vsync = 1'b1;
    @(negedge aclk);
    vsync = 1'b0;
    check("t6_swap_fcount", {16'd0, frame_count},  32'd1);
    check("t6_swap_dbank",  {31'd0, display_bank}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
